// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control sequencer for the pico MIPS core.
// Stalls PC/regfile for multiply latency and LD/ST I/O handshakes.
module exec_sequencer #(
  parameter int MLT_CYCLES = 4,
  parameter int IO_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [5:0] opcode,
  input  logic       reg_write,
  input  logic       read_in,
  input  logic       write_out,
  input  logic       pc_rel_branch,
  input  logic       in_valid,
  input  logic       out_ack,
  output logic       pc_en,
  output logic       pc_branch_en,
  output logic       reg_we,
  output logic       mult_start,
  output logic       in_ack,
  output logic       out_load,
  output logic       out_valid,
  output logic       busy,
  output logic       io_err
);

  localparam int CMAX =
    (MLT_CYCLES > IO_TIMEOUT) ? MLT_CYCLES : IO_TIMEOUT;
  localparam int CNT_W = $clog2(CMAX + 1);

  localparam logic [5:0] OP_MLT  = 6'h05;
  localparam logic [5:0] OP_MLTI = 6'h06;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MLT  = CNT_W'(MLT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_TMO  = CNT_W'(IO_TIMEOUT - 1);
  localparam bit               TMO_ON   = (IO_TIMEOUT != 0);

  typedef enum logic [1:0] {
    RUN,
    MULT,
    LD_WAIT,
    ST_WAIT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ov_nxt;
  logic             err_set;
  logic             tmo;
  logic             is_mlt;

  assign tmo    = TMO_ON && (cnt == CNT_TMO);
  assign is_mlt = (opcode == OP_MLT) || (opcode == OP_MLTI);

  always_comb begin
    pc_en        = 1'b0;
    pc_branch_en = 1'b0;
    reg_we       = 1'b0;
    mult_start   = 1'b0;
    in_ack       = 1'b0;
    out_load     = 1'b0;
    busy         = (state != RUN);
    state_nxt    = state;
    cnt_nxt      = cnt;
    ov_nxt       = out_valid;
    err_set      = 1'b0;
    unique case (state)
      RUN: begin
        if (is_mlt) begin
          mult_start = 1'b1;
          cnt_nxt    = CNT_MLT;
          state_nxt  = MULT;
        end else if (read_in) begin
          if (in_valid) begin
            in_ack = 1'b1;
            reg_we = 1'b1;
            pc_en  = 1'b1;
          end else begin
            cnt_nxt   = '0;
            state_nxt = LD_WAIT;
          end
        end else if (write_out) begin
          out_load  = 1'b1;
          cnt_nxt   = '0;
          ov_nxt    = 1'b1;
          state_nxt = ST_WAIT;
        end else begin
          pc_en        = 1'b1;
          reg_we       = reg_write;
          pc_branch_en = pc_rel_branch;
        end
      end
      MULT: begin
        if (cnt == '0) begin
          reg_we    = 1'b1;
          pc_en     = 1'b1;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      LD_WAIT: begin
        if (in_valid) begin
          in_ack    = 1'b1;
          reg_we    = 1'b1;
          pc_en     = 1'b1;
          state_nxt = RUN;
        end else if (tmo) begin
          err_set   = 1'b1;
          pc_en     = 1'b1;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (out_ack || tmo) begin
          err_set   = !out_ack;
          pc_en     = 1'b1;
          ov_nxt    = 1'b0;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = RUN;
    endcase
    // Reset must silence every strobe, even before the edge lands
    if (!n_reset) begin
      pc_en        = 1'b0;
      pc_branch_en = 1'b0;
      reg_we       = 1'b0;
      mult_start   = 1'b0;
      in_ack       = 1'b0;
      out_load     = 1'b0;
      busy         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= RUN;
      cnt       <= '0;
      out_valid <= 1'b0;
      io_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_valid <= ov_nxt;
      if (err_set) io_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: scoreboard bench for exec_sequencer.
// Per-cycle expected output vectors are queued with each stimulus row.
module tb_exec_sequencer;

  localparam logic [5:0] NOP  = 6'h00;
  localparam logic [5:0] ADD  = 6'h01;
  localparam logic [5:0] MLT  = 6'h05;
  localparam logic [5:0] MLTI = 6'h06;
  localparam logic [5:0] LD   = 6'h0A;
  localparam logic [5:0] ST   = 6'h0B;
  localparam logic [5:0] BEQ  = 6'h0C;
  localparam logic [5:0] JMP  = 6'h0D;
  localparam logic [5:0] UND  = 6'h3F;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [5:0] opcode;
  logic       reg_write, read_in, write_out, pc_rel_branch;
  logic       in_valid, out_ack;
  logic       pc_en, pc_branch_en, reg_we, mult_start;
  logic       in_ack, out_load, out_valid, busy, io_err;
  logic [8:0] obs;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rw, rd, wr, br, iv, ack;
    logic [8:0] exp;
  } row_t;

  row_t       plan[$];
  logic [8:0] sb[$];

  exec_sequencer #(
    .MLT_CYCLES(4),
    .IO_TIMEOUT(8)
  ) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .opcode       (opcode),
    .reg_write    (reg_write),
    .read_in      (read_in),
    .write_out    (write_out),
    .pc_rel_branch(pc_rel_branch),
    .in_valid     (in_valid),
    .out_ack      (out_ack),
    .pc_en        (pc_en),
    .pc_branch_en (pc_branch_en),
    .reg_we       (reg_we),
    .mult_start   (mult_start),
    .in_ack       (in_ack),
    .out_load     (out_load),
    .out_valid    (out_valid),
    .busy         (busy),
    .io_err       (io_err)
  );

  always #5 clk = ~clk;

  assign obs = {pc_en, pc_branch_en, reg_we, mult_start,
                in_ack, out_load, out_valid, busy, io_err};

  // Output vector order: pc,br,we,ms,ia,ol,ov,busy,err
  function automatic logic [8:0] ev(
    input bit pc, br, we, ms, ia, ol, ov, bz, er);
    return {pc, br, we, ms, ia, ol, ov, bz, er};
  endfunction

  function automatic row_t r(
    input logic rst, input logic [5:0] op,
    input logic rw, rd, wr, br, iv, ack,
    input logic [8:0] exp);
    row_t x;
    x.rst = rst; x.op = op; x.rw = rw; x.rd = rd;
    x.wr = wr; x.br = br; x.iv = iv; x.ack = ack;
    x.exp = exp;
    return x;
  endfunction

  task automatic drive(input row_t x);
    @(negedge clk);
    n_reset       = x.rst;
    opcode        = x.op;
    reg_write     = x.rw;
    read_in       = x.rd;
    write_out     = x.wr;
    pc_rel_branch = x.br;
    in_valid      = x.iv;
    out_ack       = x.ack;
  endtask

  task automatic test_reset;
    logic [8:0] e;
    plan.delete();
    plan.push_back(r(0, ADD, 1, 0, 0, 1, 1, 1, 9'd0));
    plan.push_back(r(0, MLT, 1, 1, 1, 1, 0, 0, 9'd0));
    foreach (plan[i]) begin
      drive(plan[i]);
      sb.push_back(plan[i].exp);
      #2;
      e = sb.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL reset c%0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_alu;
    logic [8:0] e;
    plan.delete();
    plan.push_back(r(1, ADD, 1, 0, 0, 0, 0, 0,
                     ev(1, 0, 1, 0, 0, 0, 0, 0, 0)));
    plan.push_back(r(1, NOP, 0, 0, 0, 0, 0, 0,
                     ev(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    plan.push_back(r(1, UND, 1, 0, 0, 1, 0, 0,
                     ev(1, 1, 1, 0, 0, 0, 0, 0, 0)));
    plan.push_back(r(1, ADD, 1, 0, 0, 0, 1, 1,
                     ev(1, 0, 1, 0, 0, 0, 0, 0, 0)));
    foreach (plan[i]) begin
      drive(plan[i]);
      sb.push_back(plan[i].exp);
      #2;
      e = sb.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL alu c%0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_mult;
    logic [8:0] e;
    plan.delete();
    plan.push_back(r(1, MLT, 1, 0, 0, 0, 0, 0,
                     ev(0, 0, 0, 1, 0, 0, 0, 0, 0)));
    for (int k = 0; k < 3; k++)
      plan.push_back(r(1, MLT, 1, 1, 1, 1, 1, 1,
                       ev(0, 0, 0, 0, 0, 0, 0, 1, 0)));
    plan.push_back(r(1, MLT, 1, 1, 0, 1, 1, 0,
                     ev(1, 0, 1, 0, 0, 0, 0, 1, 0)));
    plan.push_back(r(1, ADD, 1, 0, 0, 0, 0, 0,
                     ev(1, 0, 1, 0, 0, 0, 0, 0, 0)));
    foreach (plan[i]) begin
      drive(plan[i]);
      sb.push_back(plan[i].exp);
      #2;
      e = sb.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL mult c%0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_ld;
    logic [8:0] e;
    plan.delete();
    plan.push_back(r(1, LD, 1, 1, 0, 0, 0, 0,
                     ev(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    for (int k = 0; k < 3; k++)
      plan.push_back(r(1, LD, 1, 1, 0, 0, 0, 1,
                       ev(0, 0, 0, 0, 0, 0, 0, 1, 0)));
    plan.push_back(r(1, LD, 1, 1, 0, 0, 1, 0,
                     ev(1, 0, 1, 0, 1, 0, 0, 1, 0)));
    plan.push_back(r(1, LD, 1, 1, 0, 0, 1, 0,
                     ev(1, 0, 1, 0, 1, 0, 0, 0, 0)));
    plan.push_back(r(1, ADD, 1, 0, 0, 0, 1, 0,
                     ev(1, 0, 1, 0, 0, 0, 0, 0, 0)));
    foreach (plan[i]) begin
      drive(plan[i]);
      sb.push_back(plan[i].exp);
      #2;
      e = sb.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL ld c%0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_st;
    logic [8:0] e;
    plan.delete();
    plan.push_back(r(1, ST, 0, 0, 1, 0, 0, 0,
                     ev(0, 0, 0, 0, 0, 1, 0, 0, 0)));
    for (int k = 0; k < 2; k++)
      plan.push_back(r(1, ST, 0, 0, 1, 0, 1, 0,
                       ev(0, 0, 0, 0, 0, 0, 1, 1, 0)));
    plan.push_back(r(1, ST, 0, 0, 1, 0, 0, 1,
                     ev(1, 0, 0, 0, 0, 0, 1, 1, 0)));
    plan.push_back(r(1, ADD, 1, 0, 0, 0, 0, 1,
                     ev(1, 0, 1, 0, 0, 0, 0, 0, 0)));
    foreach (plan[i]) begin
      drive(plan[i]);
      sb.push_back(plan[i].exp);
      #2;
      e = sb.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL st c%0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] e;
    plan.delete();
    plan.push_back(r(1, MLTI, 1, 0, 0, 0, 0, 0,
                     ev(0, 0, 0, 1, 0, 0, 0, 0, 0)));
    for (int k = 0; k < 3; k++)
      plan.push_back(r(1, MLTI, 1, 0, 0, 0, 0, 0,
                       ev(0, 0, 0, 0, 0, 0, 0, 1, 0)));
    plan.push_back(r(1, MLTI, 1, 0, 0, 0, 0, 0,
                     ev(1, 0, 1, 0, 0, 0, 0, 1, 0)));
    plan.push_back(r(1, MLT, 1, 0, 0, 0, 0, 0,
                     ev(0, 0, 0, 1, 0, 0, 0, 0, 0)));
    for (int k = 0; k < 3; k++)
      plan.push_back(r(1, MLT, 1, 0, 0, 0, 0, 0,
                       ev(0, 0, 0, 0, 0, 0, 0, 1, 0)));
    plan.push_back(r(1, MLT, 1, 0, 0, 0, 0, 0,
                     ev(1, 0, 1, 0, 0, 0, 0, 1, 0)));
    plan.push_back(r(1, ST, 0, 0, 1, 0, 0, 0,
                     ev(0, 0, 0, 0, 0, 1, 0, 0, 0)));
    plan.push_back(r(1, ST, 0, 0, 1, 0, 0, 1,
                     ev(1, 0, 0, 0, 0, 0, 1, 1, 0)));
    plan.push_back(r(1, LD, 1, 1, 0, 0, 1, 0,
                     ev(1, 0, 1, 0, 1, 0, 0, 0, 0)));
    foreach (plan[i]) begin
      drive(plan[i]);
      sb.push_back(plan[i].exp);
      #2;
      e = sb.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL b2b c%0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_priority;
    logic [8:0] e;
    plan.delete();
    plan.push_back(r(1, LD, 1, 1, 0, 0, 0, 0,
                     ev(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    for (int k = 0; k < 7; k++)
      plan.push_back(r(1, LD, 1, 1, 0, 0, 0, 0,
                       ev(0, 0, 0, 0, 0, 0, 0, 1, 0)));
    plan.push_back(r(1, LD, 1, 1, 0, 0, 1, 0,
                     ev(1, 0, 1, 0, 1, 0, 0, 1, 0)));
    plan.push_back(r(1, ADD, 1, 0, 0, 0, 0, 0,
                     ev(1, 0, 1, 0, 0, 0, 0, 0, 0)));
    foreach (plan[i]) begin
      drive(plan[i]);
      sb.push_back(plan[i].exp);
      #2;
      e = sb.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL prio c%0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_timeout;
    logic [8:0] e;
    plan.delete();
    plan.push_back(r(1, LD, 1, 1, 0, 0, 0, 0,
                     ev(0, 0, 0, 0, 0, 0, 0, 0, 0)));
    for (int k = 0; k < 7; k++)
      plan.push_back(r(1, LD, 1, 1, 0, 0, 0, 0,
                       ev(0, 0, 0, 0, 0, 0, 0, 1, 0)));
    plan.push_back(r(1, LD, 1, 1, 0, 0, 0, 0,
                     ev(1, 0, 0, 0, 0, 0, 0, 1, 0)));
    for (int k = 0; k < 20; k++)
      plan.push_back(r(1, ADD, 1, 0, 0, 0, 0, 0,
                       ev(1, 0, 1, 0, 0, 0, 0, 0, 1)));
    plan.push_back(r(1, ST, 0, 0, 1, 0, 0, 0,
                     ev(0, 0, 0, 0, 0, 1, 0, 0, 1)));
    for (int k = 0; k < 7; k++)
      plan.push_back(r(1, ST, 0, 0, 1, 0, 0, 0,
                       ev(0, 0, 0, 0, 0, 0, 1, 1, 1)));
    plan.push_back(r(1, ST, 0, 0, 1, 0, 0, 0,
                     ev(1, 0, 0, 0, 0, 0, 1, 1, 1)));
    plan.push_back(r(1, NOP, 0, 0, 0, 0, 0, 0,
                     ev(1, 0, 0, 0, 0, 0, 0, 0, 1)));
    foreach (plan[i]) begin
      drive(plan[i]);
      sb.push_back(plan[i].exp);
      #2;
      e = sb.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL tmo c%0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_branch;
    logic [8:0] e;
    plan.delete();
    plan.push_back(r(1, BEQ, 0, 0, 0, 1, 0, 0,
                     ev(1, 1, 0, 0, 0, 0, 0, 0, 1)));
    plan.push_back(r(1, BEQ, 0, 0, 0, 0, 0, 0,
                     ev(1, 0, 0, 0, 0, 0, 0, 0, 1)));
    plan.push_back(r(1, JMP, 0, 0, 0, 1, 0, 0,
                     ev(1, 1, 0, 0, 0, 0, 0, 0, 1)));
    plan.push_back(r(1, MLT, 1, 0, 0, 1, 0, 0,
                     ev(0, 0, 0, 1, 0, 0, 0, 0, 1)));
    for (int k = 0; k < 3; k++)
      plan.push_back(r(1, MLT, 1, 0, 0, 1, 0, 0,
                       ev(0, 0, 0, 0, 0, 0, 0, 1, 1)));
    plan.push_back(r(1, MLT, 1, 0, 0, 1, 0, 0,
                     ev(1, 0, 1, 0, 0, 0, 0, 1, 1)));
    foreach (plan[i]) begin
      drive(plan[i]);
      sb.push_back(plan[i].exp);
      #2;
      e = sb.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL branch c%0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [8:0] e;
    plan.delete();
    plan.push_back(r(1, MLT, 1, 0, 0, 0, 0, 0,
                     ev(0, 0, 0, 1, 0, 0, 0, 0, 1)));
    for (int k = 0; k < 2; k++)
      plan.push_back(r(1, MLT, 1, 0, 0, 0, 0, 0,
                       ev(0, 0, 0, 0, 0, 0, 0, 1, 1)));
    plan.push_back(r(0, MLT, 1, 0, 0, 0, 0, 0, 9'd0));
    plan.push_back(r(1, NOP, 0, 0, 0, 0, 0, 0,
                     ev(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    plan.push_back(r(1, NOP, 0, 0, 0, 0, 0, 0,
                     ev(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    plan.push_back(r(1, ST, 0, 0, 1, 0, 0, 0,
                     ev(0, 0, 0, 0, 0, 1, 0, 0, 0)));
    plan.push_back(r(1, ST, 0, 0, 1, 0, 0, 0,
                     ev(0, 0, 0, 0, 0, 0, 1, 1, 0)));
    plan.push_back(r(0, ST, 0, 0, 1, 0, 0, 1, 9'd0));
    plan.push_back(r(1, ADD, 1, 0, 0, 0, 0, 1,
                     ev(1, 0, 1, 0, 0, 0, 0, 0, 0)));
    foreach (plan[i]) begin
      drive(plan[i]);
      sb.push_back(plan[i].exp);
      #2;
      e = sb.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL rstmid c%0d: got %b want %b", i, obs, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    n_reset       = 1'b0;
    opcode        = NOP;
    reg_write     = 1'b0;
    read_in       = 1'b0;
    write_out     = 1'b0;
    pc_rel_branch = 1'b0;
    in_valid      = 1'b0;
    out_ack       = 1'b0;
    test_reset();
    test_alu();
    test_mult();
    test_ld();
    test_st();
    test_back_to_back();
    test_priority();
    test_timeout();
    test_branch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
